// File: rtl/param_shift_count_reg.sv
// Parametrised multi-mode register: hold, logical shift, rotate, parallel load
// and up/down count, with selectable active clock edge and asynchronous reset.
module param_shift_count_reg #(
    parameter int unsigned          WIDTH     = 4,
    parameter bit                   NEG_EDGE  = 1'b1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             C,
    input  logic             RE,
    input  logic             CLR,
    input  logic             EN,
    input  logic [2:0]       M,
    input  logic [WIDTH-1:0] D,
    input  logic             SIR,
    input  logic             SIL,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qnot,
    output logic             TC
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_UP   = 3'b110;
    localparam logic [2:0] MODE_DOWN = 3'b111;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_tc;

    // Next state: clear beats enable, enable gates the mode operation
    always_comb begin
        w_q_next = r_q;
        if (CLR) begin
            w_q_next = '0;
        end else if (EN) begin
            case (M)
                MODE_HOLD: w_q_next = r_q;
                MODE_SHR:  w_q_next = {SIR, r_q[WIDTH-1:1]};
                MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], SIL};
                MODE_LOAD: w_q_next = D;
                MODE_ROR:  w_q_next = {r_q[0], r_q[WIDTH-1:1]};
                MODE_ROL:  w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                MODE_UP:   w_q_next = r_q + WIDTH'(1);
                MODE_DOWN: w_q_next = r_q - WIDTH'(1);
                default:   w_q_next = r_q;
            endcase
        end
    end

    // State register on the edge chosen at elaboration
    if (NEG_EDGE) begin : g_neg_edge
        always_ff @(negedge C or posedge RE) begin
            if (RE) begin
                r_q <= RESET_VAL;
            end else begin
                r_q <= w_q_next;
            end
        end
    end else begin : g_pos_edge
        always_ff @(posedge C or posedge RE) begin
            if (RE) begin
                r_q <= RESET_VAL;
            end else begin
                r_q <= w_q_next;
            end
        end
    end

    // Terminal count looks only at current state and mode
    always_comb begin
        w_tc = 1'b0;
        if ((M == MODE_UP) && (&r_q)) begin
            w_tc = 1'b1;
        end else if ((M == MODE_DOWN) && (r_q == '0)) begin
            w_tc = 1'b1;
        end
    end

    assign Q    = r_q;
    assign Qnot = ~r_q;
    assign TC   = w_tc;

endmodule

// File: tb/tb_param_shift_count_reg.sv
// Bench for param_shift_count_reg: directed vector table, hand-written corner
// sequences and a randomized run against an arithmetic reference model.
module tb_param_shift_count_reg;

    localparam int unsigned W   = 4;
    localparam int          RST = 10; // 4'b1010

    logic         c;
    logic         re, clr, en, sir, sil;
    logic [2:0]   m;
    logic [W-1:0] d, q, qnot;
    logic         tc;

    logic         re2, clr2, en2, sir2, sil2;
    logic [2:0]   m2;
    logic [W-1:0] d2, q2, qnot2;
    logic         tc2;

    int errors = 0;
    int checks = 0;
    int ref_q;

    param_shift_count_reg #(.WIDTH(W), .NEG_EDGE(1'b1), .RESET_VAL(4'b1010)) dut (
        .C(c), .RE(re), .CLR(clr), .EN(en), .M(m), .D(d), .SIR(sir), .SIL(sil),
        .Q(q), .Qnot(qnot), .TC(tc)
    );

    param_shift_count_reg #(.WIDTH(W), .NEG_EDGE(1'b0), .RESET_VAL(4'b0000)) dut_pos (
        .C(c), .RE(re2), .CLR(clr2), .EN(en2), .M(m2), .D(d2), .SIR(sir2), .SIL(sil2),
        .Q(q2), .Qnot(qnot2), .TC(tc2)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    typedef struct {
        logic       clr;
        logic       en;
        logic [2:0] m;
        logic [3:0] d;
        logic       sir;
        logic       sil;
        int         exp_q;
        logic       exp_tc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic cl, input logic e, input int mm, input int dd,
                                input logic sr, input logic sl, input int eq, input logic et);
        vec_t v;
        v.clr = cl; v.en = e; v.m = 3'(mm); v.d = 4'(dd);
        v.sir = sr; v.sil = sl; v.exp_q = eq; v.exp_tc = et;
        return v;
    endfunction

    // Reference behaviour expressed with plain integer arithmetic
    function automatic int model_next(input int cur, input logic cl, input logic e, input int mm,
                                      input int dd, input logic sr, input logic sl);
        if (cl) return 0;
        if (!e) return cur;
        case (mm)
            1: return (cur / 2) + (sr ? 8 : 0);
            2: return ((cur * 2) % 16) + (sl ? 1 : 0);
            3: return dd;
            4: return (cur / 2) + ((cur % 2) * 8);
            5: return ((cur * 2) % 16) + (cur / 8);
            6: return (cur + 1) % 16;
            7: return (cur + 15) % 16;
            default: return cur;
        endcase
    endfunction

    function automatic logic model_tc(input int cur, input int mm);
        return ((mm == 6) && (cur == 15)) || ((mm == 7) && (cur == 0));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge c);
        #1;
    endtask

    task automatic check_all(input string name, input int exp_q);
        check({name, " q"}, 32'(q), exp_q);
        check({name, " qnot"}, 32'(qnot), (~exp_q) & 15);
        check({name, " tc"}, 32'(tc), 32'(model_tc(exp_q, int'(m))));
    endtask

    initial begin
        re = 1'b1; clr = 1'b0; en = 1'b0; m = 3'd0; d = '0; sir = 1'b0; sil = 1'b0;
        re2 = 1'b1; clr2 = 1'b0; en2 = 1'b0; m2 = 3'd0; d2 = '0; sir2 = 1'b0; sil2 = 1'b0;

        // Reset held: value forced and kept across active edges
        #2;
        check("reset q", 32'(q), RST);
        check("reset qnot", 32'(qnot), 5);
        check("reset tc", 32'(tc), 0);
        en = 1'b1; m = 3'd6;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset hold q", 32'(q), RST);
        end
        re = 1'b0;

        // Directed sequence from the reset value
        tbl.push_back(mk(0, 1, 3, 9,  0, 0, 9,  0));
        tbl.push_back(mk(0, 1, 1, 0,  1, 0, 12, 0));
        tbl.push_back(mk(0, 1, 1, 0,  1, 0, 14, 0));
        tbl.push_back(mk(0, 1, 2, 0,  0, 0, 12, 0));
        tbl.push_back(mk(0, 1, 3, 9,  0, 0, 9,  0));
        tbl.push_back(mk(0, 1, 4, 0,  0, 0, 12, 0));
        tbl.push_back(mk(0, 1, 4, 0,  0, 0, 6,  0));
        tbl.push_back(mk(0, 1, 4, 0,  0, 0, 3,  0));
        tbl.push_back(mk(0, 1, 4, 0,  0, 0, 9,  0));
        tbl.push_back(mk(0, 1, 5, 0,  0, 0, 3,  0));
        tbl.push_back(mk(0, 1, 3, 14, 0, 0, 14, 0));
        tbl.push_back(mk(0, 0, 6, 0,  0, 0, 14, 0));
        tbl.push_back(mk(0, 1, 6, 0,  0, 0, 15, 1));
        tbl.push_back(mk(0, 1, 6, 0,  0, 0, 0,  0));
        tbl.push_back(mk(0, 0, 7, 0,  0, 0, 0,  1));
        tbl.push_back(mk(0, 1, 7, 0,  0, 0, 15, 0));
        tbl.push_back(mk(0, 0, 6, 0,  0, 0, 15, 1));
        tbl.push_back(mk(0, 0, 6, 0,  0, 0, 15, 1));
        tbl.push_back(mk(0, 0, 6, 0,  0, 0, 15, 1));
        tbl.push_back(mk(1, 0, 3, 7,  0, 0, 0,  0));

        foreach (tbl[i]) begin
            clr = tbl[i].clr; en = tbl[i].en; m = tbl[i].m; d = tbl[i].d;
            sir = tbl[i].sir; sil = tbl[i].sil;
            step();
            check($sformatf("vec%0d q", i), 32'(q), tbl[i].exp_q);
            check($sformatf("vec%0d tc", i), 32'(tc), 32'(tbl[i].exp_tc));
        end
        clr = 1'b0;

        // Reset pulse between edges, clock not toggling across it
        re = 1'b1;
        #2;
        check_all("async reset", RST);
        re = 1'b0;

        // Reset rising just before an active edge while clear is requested
        clr = 1'b1; en = 1'b1; m = 3'd6;
        @(posedge c);
        #4;
        re = 1'b1;
        @(negedge c);
        #1;
        check_all("reset vs clr", RST);
        re = 1'b0;
        clr = 1'b0;

        // Randomized operation with occasional asynchronous reset pulses
        ref_q = RST;
        for (int i = 0; i < 300; i++) begin
            clr = ($urandom_range(0, 15) == 0);
            en  = ($urandom_range(0, 7) != 0);
            m   = 3'($urandom_range(0, 7));
            d   = 4'($urandom_range(0, 15));
            sir = 1'($urandom_range(0, 1));
            sil = 1'($urandom_range(0, 1));
            ref_q = model_next(ref_q, clr, en, int'(m), int'(d), sir, sil);
            step();
            check_all("rand", ref_q);
            if ($urandom_range(0, 24) == 0) begin
                re = 1'b1;
                #1;
                ref_q = RST;
                check_all("rand reset", ref_q);
                re = 1'b0;
            end
        end

        // Rising-edge instance: counts on rising edges, steady on falling edges
        re2 = 1'b1;
        #1;
        re2 = 1'b0;
        en2 = 1'b1; m2 = 3'd6;
        check("pos reset q", 32'(q2), 0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge c);
            #1;
            check($sformatf("pos rise%0d q", k), 32'(q2), k);
            @(negedge c);
            #1;
            check($sformatf("pos fall%0d q", k), 32'(q2), k);
        end
        check("pos qnot", 32'(qnot2), 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/param_shift_count_reg.md
Name: param_shift_count_reg

Overview:
- Parametrised multi-mode register (WIDTH bits) built on the team's D flip-flop style storage.
- Successor to the single-bit D flip-flop with synchronous clear.
- Adds width generalisation, selectable clock edge, and an asynchronous reset.
- Adds eight operating modes: hold, logical shifts, rotates, parallel load and up/down count.
- Used as a general register, serial-parallel converter or counter in datapath and lab assemblies.

Parameters:
- WIDTH, 4, register width in bits; minimum 2.
- NEG_EDGE, 1, 1 = state updates on falling edge of C; 0 = rising edge.
- RESET_VAL, 0, WIDTH-bit value loaded into Q by RE.

Ports:
- C  input  1  clock; the active edge is selected by NEG_EDGE.
- RE  input  1  reset, asynchronous, active-high.
- CLR  input  1  synchronous clear, active-high.
- EN  input  1  clock enable, active-high.
- M  input  3  mode select.
- D  input  WIDTH  parallel load data.
- SIR  input  1  serial input entering at MSB during shift right.
- SIL  input  1  serial input entering at LSB during shift left.
- Q  output  WIDTH  register state.
- Qnot  output  WIDTH  bitwise complement of Q, always ~Q.
- TC  output  1  terminal count, combinational from Q and M.

Behaviour:
- Single clock C. Reset is asynchronous and active-high. The clock port is C and the reset port is RE.
- RE high: Q = RESET_VAL immediately, regardless of C. Q holds while RE is high. Qnot = ~RESET_VAL.
- RE deassertion is not synchronised internally. The first update occurs on the first active edge after RE falls.
- On each active edge (RE low), priority from highest to lowest:
  - CLR=1: Q <= 0, regardless of EN and M.
  - EN=0: Q holds.
  - EN=1: Q updates per M.
- M encoding (EN=1, CLR=0):
  - 000 hold: Q <= Q.
  - 001 shift right: Q <= {SIR, Q[WIDTH-1:1]}.
  - 010 shift left: Q <= {Q[WIDTH-2:0], SIL}.
  - 011 parallel load: Q <= D.
  - 100 rotate right: Q <= {Q[0], Q[WIDTH-1:1]}.
  - 101 rotate left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 110 count up: Q <= Q + 1, modulo 2^WIDTH. All-ones wraps to 0.
  - 111 count down: Q <= Q - 1, modulo 2^WIDTH. 0 wraps to all-ones.
- Latency: one active edge from inputs to Q.
- All inputs are sampled at the active edge only. Changes between edges have no effect (no latch transparency).
- TC:
  - 1 when M=110 and Q is all-ones.
  - 1 when M=111 and Q = 0.
  - 0 otherwise.
  - TC is independent of EN and CLR. It is 0 while RE is high unless RESET_VAL and M satisfy the rule above.
- Simultaneous events:
  - RE asserted coincident with an active edge: RE wins, Q = RESET_VAL.
  - CLR with any M: clear wins.
- RE asserted mid-operation (e.g. mid-count or mid-shift): state is lost and no pending update is applied.
- NEG_EDGE=1: Q never changes on the rising edge of C. NEG_EDGE=0: Q never changes on the falling edge.
- No X propagation from unused serial inputs. SIR/SIL are only sampled in modes 001/010.

Test Plan:
- Reset: WIDTH=4, RESET_VAL=4'b1010. Pulse RE between edges with C static → Q=1010 and Qnot=0101 without any clock edge. Q stays 1010 for 3 edges while RE=1.
- Load/shift:
  - M=011, D=1001, one falling edge → Q=1001.
  - Then M=001, SIR=1 for 2 edges → Q=1100 then 1110.
  - Then M=010, SIL=0 → Q=1100.
- Rotate: Q=1001, M=100 for 4 edges → 1100, 0110, 0011, 1001. M=101 for 1 edge → 0011.
- Count wrap:
  - Q=1110, M=110 → TC=0. Next edge Q=1111 and TC=1. Next edge Q=0000 and TC=0.
  - M=111 at Q=0000 → TC=1. Next edge Q=1111.
- Priority:
  - EN=0, M=110, 3 edges → Q unchanged.
  - CLR=1 with EN=0, M=011, D=0111 → Q=0000.
  - RE rising 1 ns before an edge while CLR=1 → Q=RESET_VAL.
- Edge select: NEG_EDGE=0 instance, M=110 from Q=0 → Q increments on rising edges only. Q=0011 after 3 rising edges, with no change on falling edges.
